// File: rtl/cpu_regfile_pkg.sv
// cpu_regfile_pkg: shared definitions for the CPU general-purpose register file.
//   OP_WIDTH : width of the controller op field
//   op_e     : operation encodings; codes 5..7 are undefined and act as NOP
package cpu_regfile_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_MOV  = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } op_e;

endpackage

// File: rtl/cpu_regfile_incdec.sv
// cpu_regfile_incdec: combinational +1 / -1 unit for in-place register ops.
//   a_i     : operand
//   dec_i   : 1 = decrement, 0 = increment
//   res_o   : result modulo 2^DATA_WIDTH
//   carry_o : carry-out on increment, borrow on decrement
module cpu_regfile_incdec #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  dec_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  carry_o
);

    logic [DATA_WIDTH:0] ext;
    logic [DATA_WIDTH:0] one;
    logic [DATA_WIDTH:0] sum;

    assign ext = {1'b0, a_i};
    assign one = {{DATA_WIDTH{1'b0}}, 1'b1};
    // The extra top bit is the carry on +1 and wraps to 1 (borrow) only on 0-1.
    assign sum     = dec_i ? (ext - one) : (ext + one);
    assign res_o   = sum[DATA_WIDTH-1:0];
    assign carry_o = sum[DATA_WIDTH];

endmodule

// File: rtl/cpu_register_file.sv
// cpu_register_file: parametrised register bank between the data bus and the ALU.
//   clk, reset              : clock, synchronous active-high reset
//   op                      : NOP/LOAD/MOV/INC/DEC (see cpu_regfile_pkg)
//   sel_in                  : destination register
//   sel_out                 : bus-read register and MOV source
//   data_in                 : bus value for LOAD
//   output_enable, data_out : tristate bus read of reg[sel_out]
//   alu_sel_a/b, alu_a/b    : ALU operand read ports (optionally bypassed)
//   flag_zero, flag_carry   : registered result flags
module cpu_register_file
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_REGS),
    parameter int BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [SEL_WIDTH-1:0]  sel_in,
    input  logic [SEL_WIDTH-1:0]  sel_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  output_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [SEL_WIDTH-1:0]  alu_sel_a,
    input  logic [SEL_WIDTH-1:0]  alu_sel_b,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic                  flag_zero,
    output logic                  flag_carry
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  flag_zero_q, flag_zero_d;
    logic                  flag_carry_q, flag_carry_d;

    logic [DATA_WIDTH-1:0] src_val, dst_old, wr_data, incdec_res;
    logic                  incdec_carry, upd, wr_en;

    // Selects beyond the populated registers read as zero.
    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [SEL_WIDTH-1:0] sel);
        if (int'(sel) < NUM_REGS) return regs_q[sel];
        return '0;
    endfunction

    assign src_val = read_reg(sel_out);
    assign dst_old = read_reg(sel_in);

    cpu_regfile_incdec #(.DATA_WIDTH(DATA_WIDTH)) u_incdec (
        .a_i     (dst_old),
        .dec_i   (op == OP_DEC),
        .res_o   (incdec_res),
        .carry_o (incdec_carry)
    );

    always_comb begin
        upd          = 1'b0;
        wr_data      = dst_old;
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        case (op)
            OP_LOAD: begin
                upd          = 1'b1;
                wr_data      = data_in;
                flag_carry_d = 1'b0;
            end
            OP_MOV: begin
                upd          = 1'b1;
                wr_data      = src_val;
                flag_carry_d = 1'b0;
            end
            OP_INC, OP_DEC: begin
                upd          = 1'b1;
                wr_data      = incdec_res;
                flag_carry_d = incdec_carry;
            end
            default: ;
        endcase
        // Flags follow the computed result even when the write is dropped.
        if (upd) flag_zero_d = (wr_data == '0);
    end

    // Reset is folded in so the bypass never shows a write that reset discards.
    assign wr_en = upd && (int'(sel_in) < NUM_REGS) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            if (wr_en) regs_q[sel_in] <= wr_data;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
        end
    end

    assign alu_a = (BYP_EN && wr_en && sel_in == alu_sel_a) ? wr_data : read_reg(alu_sel_a);
    assign alu_b = (BYP_EN && wr_en && sel_in == alu_sel_b) ? wr_data : read_reg(alu_sel_b);

    // Bus port always shows the stored value, never the in-flight write.
    assign data_out   = output_enable ? src_val : {DATA_WIDTH{1'bz}};
    assign flag_zero  = flag_zero_q;
    assign flag_carry = flag_carry_q;

endmodule
